apb_timer_nch: RTL and testbench
================================

# apb_timer_nch

Parametrised multi-channel APB timer/counter. It is the successor to `timer_counter_8bit` plus its separate `prescaler`, and replaces both. It provides NUM_CH independent counters of DATA_WIDTH bits, each with selectable up/down direction, a clock-divide select, optional auto-reload, sticky write-1-to-clear status flags and per-channel interrupt enables, all behind one zero-wait-state APB slave. The prescaler is internal and runs off pclk as a clock-enable generator, so the whole block sits in a single clock domain.

## Interface
- DATA_WIDTH, 8: counter, TDR and APB data width; legal range 8..32.
- NUM_CH, 2: number of timer channels; legal range 1..8.
- ADDR_WIDTH, 5: APB address width; must be at least 2 + clog2(NUM_CH).
- pclk  in  1  the only clock; all state updates on the rising edge.
- preset  in  1  synchronous, active-high reset.
- psel, penable, pwrite  in  1 each  APB control.
- paddr  in  ADDR_WIDTH  byte-agnostic register index.
- pwdata  in  DATA_WIDTH  write data.
- prdata  out  DATA_WIDTH  read data.
- pready  out  1  transfer complete.
- pslverr  out  1  transfer error.
- tmr_ovf  out  NUM_CH  per-channel sticky overflow flag.
- tmr_udf  out  NUM_CH  per-channel sticky underflow flag.
- irq  out  1  combined interrupt.

## Operation
- Register map: channel c occupies paddr = 4c + offset.
  - Offset 0, TDR (R/W): reload/load value.
  - Offset 1, TCR (R/W): control, bits below.
  - Offset 2, TSR: status. Bit0 = ovf, bit1 = udf. Write 1 to clear a bit; writing 0 has no effect.
  - Offset 3, TCNT (RO): current count.
- TCR bits. Unused upper bits read 0.
  - [7] load: self-clearing and always reads 0. Writing 1 sets TCNT to TDR on the write edge and suppresses counting on that edge.
  - [6] arl: auto-reload.
  - [5] down: 1 = count down, 0 = count up.
  - [4] en: counting enable.
  - [3] ovf_ie, [2] udf_ie: interrupt enables.
  - [1:0] cks: tick every 2^(cks+1) pclk cycles, i.e. divide by 2, 4, 8 or 16.
- Prescaler: a 4-bit free-running counter pre that increments every cycle. Channel tick = (pre[cks:0] all ones). All channels share pre.
- Counting, applied when en=1 and tick=1:
  - Up: TCNT+1. At the maximum value 2^DATA_WIDTH−1, the next count is TDR if arl=1, else 0, and ovf is set.
  - Down: TCNT−1. At 0, the next count is TDR if arl=1, else the maximum value, and udf is set.
- Priority on one edge, highest first: preset, then load, then count. A hardware flag set wins over a same-edge W1C clear of that flag.
- APB:
  - Writes commit on the edge where psel & penable & pwrite.
  - pready = 1 whenever psel & penable (zero wait states).
  - pslverr = 1 in the access phase when the channel index ≥ NUM_CH, or on a write to TCNT. Such a write has no effect.
  - prdata = the selected register when psel & !pwrite and the address is valid; otherwise 0. prdata is combinational.
- irq = OR over c of (ovf[c] & ovf_ie[c]) | (udf[c] & udf_ie[c]). It is combinational from registers.
- tmr_ovf[c] and tmr_udf[c] drive the TSR bits directly.

## Timing
- Reset values: all TDR, TCR, TSR, TCNT and pre = 0. Outputs prdata = 0, pready = 0, pslverr = 0, tmr_ovf = 0, tmr_udf = 0, irq = 0.
- Reset asserted mid-count clears everything on the next edge. The first tick after release comes 2^(cks+1) cycles later.
- Write latency: the new register value is visible to reads and to counting from the cycle after the access edge.
- Enable latency: the first count comes within 2^(cks+1) cycles of the en write, depending on the pre phase.
- Flags set on the same edge as the wrapping count. irq rises in the same cycle.
- Changing cks while enabled takes effect at the next matching pre value. No count is lost or doubled beyond that phase.
- Clearing en freezes TCNT immediately. Flags are retained.

## Test plan
- Reset: hold preset for 2 cycles. Every register reads 0, all outputs are 0, and pready = 1 during each access.
- Up with auto-reload, ch0:
  - Stimulus: TDR = 0xFC, TCR = 0x80, then TCR = 0x50 (arl, en, cks = 0).
  - TCNT steps FC, FD, FE, FF, FC, one step every 2 cycles.
  - tmr_ovf[0] rises on the FF→FC edge. TSR reads 0x01.
- Down without reload, ch1:
  - Stimulus: TDR = 0x02, load, then TCR = 0x3B (down, en, ovf_ie, cks = 3).
  - TCNT goes 02→01→00→FF, one step every 16 cycles.
  - tmr_udf[1] = 1. irq stays 0 because udf_ie = 0. Setting udf_ie makes irq = 1.
- W1C race: program ch0 to overflow on edge N and write TSR = 0x01 at edge N. ovf remains 1. A second TSR = 0x01 write clears it, and irq falls the next cycle.
- Errors: a read of paddr 4·NUM_CH gives pslverr = 1 and prdata = 0. A write of 0x55 to TCNT gives pslverr = 1 and leaves TCNT unchanged.
- Channel independence: ch0 runs at cks = 0 up and ch1 at cks = 2 down, concurrently. Each TCNT matches its own model, and flags never cross channels.

Source files
------------

// File: rtl/apb_timer_nch.sv
// -----------------------------------------------------------------------------
// apb_timer_nch
//
// NUM_CH independent DATA_WIDTH-bit timer/counters behind a zero-wait-state
// APB slave. Each channel has a reload register (TDR), a control register
// (TCR), sticky write-1-to-clear status flags (TSR) and a read-only count
// (TCNT). A shared 4-bit free-running prescaler produces the per-channel
// clock enables, so the block runs entirely in the pclk domain.
//
// Register map (channel c): paddr = 4*c + {0:TDR, 1:TCR, 2:TSR, 3:TCNT}
//
// Ports
//   pclk, preset          clock and synchronous active-high reset
//   psel/penable/pwrite   APB control
//   paddr, pwdata         APB address (register index) and write data
//   prdata                combinational read data (0 when not reading)
//   pready, pslverr       access complete / access error
//   tmr_ovf, tmr_udf      per-channel sticky overflow / underflow flags
//   irq                   OR of all enabled flags
// -----------------------------------------------------------------------------
module apb_timer_nch #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [NUM_CH-1:0]     tmr_ovf,
  output logic [NUM_CH-1:0]     tmr_udf,
  output logic                  irq
);

  localparam int CH_IDX_W = ADDR_WIDTH - 2;

  localparam logic [1:0] OFF_TDR  = 2'd0;
  localparam logic [1:0] OFF_TCR  = 2'd1;
  localparam logic [1:0] OFF_TSR  = 2'd2;
  localparam logic [1:0] OFF_TCNT = 2'd3;

  // Address decode: upper bits pick the channel, low two bits the register.
  logic [CH_IDX_W-1:0] ch_idx;
  logic [1:0]          reg_off;
  logic                access;
  logic                wr_commit;
  logic                addr_valid;

  assign ch_idx    = paddr[ADDR_WIDTH-1:2];
  assign reg_off   = paddr[1:0];
  assign access    = psel & penable;
  assign wr_commit = access & pwrite;

  // Shared prescaler; every channel derives its tick from the low bits.
  logic [3:0] pre_reg;

  always_ff @(posedge pclk) begin
    if (preset) begin
      pre_reg <= '0;
    end else begin
      pre_reg <= pre_reg + 4'd1;
    end
  end

  logic [NUM_CH-1:0]     ch_sel;
  logic [NUM_CH-1:0]     ch_irq;
  logic [DATA_WIDTH-1:0] ch_rdata [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DATA_WIDTH-1:0] tdr_reg;
      logic [DATA_WIDTH-1:0] tcnt_reg;
      logic [DATA_WIDTH-1:0] tcnt_next;
      logic [6:0]            tcr_reg;    // load bit is never stored
      logic                  ovf_reg;
      logic                  udf_reg;
      logic                  tick;
      logic                  wr_tdr;
      logic                  wr_tcr;
      logic                  wr_tsr;
      logic                  load;
      logic                  ovf_next;
      logic                  udf_next;
      logic [DATA_WIDTH-1:0] rd_mux;

      // TCR field aliases
      logic       arl;
      logic       down;
      logic       en;
      logic       ovf_ie;
      logic       udf_ie;
      logic [1:0] cks;

      assign arl    = tcr_reg[6];
      assign down   = tcr_reg[5];
      assign en     = tcr_reg[4];
      assign ovf_ie = tcr_reg[3];
      assign udf_ie = tcr_reg[2];
      assign cks    = tcr_reg[1:0];

      assign ch_sel[gi] = (ch_idx == CH_IDX_W'(gi));
      assign wr_tdr     = wr_commit & ch_sel[gi] & (reg_off == OFF_TDR);
      assign wr_tcr     = wr_commit & ch_sel[gi] & (reg_off == OFF_TCR);
      assign wr_tsr     = wr_commit & ch_sel[gi] & (reg_off == OFF_TSR);
      assign load       = wr_tcr & pwdata[7];

      // Tick when the low cks+1 prescaler bits are all ones.
      always_comb begin
        case (cks)
          2'd0:    tick = pre_reg[0];
          2'd1:    tick = &pre_reg[1:0];
          2'd2:    tick = &pre_reg[2:0];
          default: tick = &pre_reg;
        endcase
      end

      // Next count and wrap flags, ignoring load (handled with priority below).
      always_comb begin
        tcnt_next = tcnt_reg;
        ovf_next  = 1'b0;
        udf_next  = 1'b0;
        if (en && tick) begin
          if (!down) begin
            if (&tcnt_reg) begin
              tcnt_next = arl ? tdr_reg : '0;
              ovf_next  = 1'b1;
            end else begin
              tcnt_next = tcnt_reg + DATA_WIDTH'(1);
            end
          end else begin
            if (tcnt_reg == '0) begin
              tcnt_next = arl ? tdr_reg : '1;
              udf_next  = 1'b1;
            end else begin
              tcnt_next = tcnt_reg - DATA_WIDTH'(1);
            end
          end
        end
      end

      always_ff @(posedge pclk) begin
        if (preset) begin
          tdr_reg  <= '0;
          tcr_reg  <= '0;
          tcnt_reg <= '0;
          ovf_reg  <= 1'b0;
          udf_reg  <= 1'b0;
        end else begin
          if (wr_tdr) begin
            tdr_reg <= pwdata;
          end
          if (wr_tcr) begin
            tcr_reg <= pwdata[6:0];
          end
          // Load beats counting; a suppressed count also cannot raise a flag.
          if (load) begin
            tcnt_reg <= tdr_reg;
          end else begin
            tcnt_reg <= tcnt_next;
          end
          // Hardware set wins over a same-edge write-1-to-clear.
          ovf_reg <= (ovf_next & ~load) | (ovf_reg & ~(wr_tsr & pwdata[0]));
          udf_reg <= (udf_next & ~load) | (udf_reg & ~(wr_tsr & pwdata[1]));
        end
      end

      always_comb begin
        case (reg_off)
          OFF_TDR: rd_mux = tdr_reg;
          OFF_TCR: rd_mux = DATA_WIDTH'({1'b0, tcr_reg});
          OFF_TSR: rd_mux = DATA_WIDTH'({udf_reg, ovf_reg});
          default: rd_mux = tcnt_reg;
        endcase
      end

      assign ch_rdata[gi] = ch_sel[gi] ? rd_mux : '0;
      assign ch_irq[gi]   = (ovf_reg & ovf_ie) | (udf_reg & udf_ie);
      assign tmr_ovf[gi]  = ovf_reg;
      assign tmr_udf[gi]  = udf_reg;
    end
  endgenerate

  // Channel indices at or beyond NUM_CH select nothing.
  assign addr_valid = |ch_sel;

  always_comb begin
    prdata = '0;
    if (psel && !pwrite && addr_valid) begin
      for (int c = 0; c < NUM_CH; c++) begin
        prdata = prdata | ch_rdata[c];
      end
    end
  end

  assign pready  = access;
  assign pslverr = access & (~addr_valid | (pwrite & (reg_off == OFF_TCNT)));
  assign irq     = |ch_irq;

endmodule

// File: tb/tb_apb_timer_nch.sv
module tb_apb_timer_nch;

  localparam int NCH  = 2;
  localparam int MAXV = 255;

  logic       pclk;
  logic       preset;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [4:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;
  logic [1:0] tmr_ovf;
  logic [1:0] tmr_udf;
  logic       irq;

  apb_timer_nch #(.DATA_WIDTH(8), .NUM_CH(NCH), .ADDR_WIDTH(5)) dut (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .tmr_ovf (tmr_ovf),
    .tmr_udf (tmr_udf),
    .irq     (irq)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: registers as plain integers, prescaler as a cycle count.
  // ---------------------------------------------------------------------------
  int m_tdr  [NCH];
  int m_tcr  [NCH];
  int m_tcnt [NCH];
  bit m_ovf  [NCH];
  bit m_udf  [NCH];
  int m_cyc;
  bit m_valid = 1'b0;

  initial begin
    forever begin
      @(posedge pclk);
      if (preset) begin
        for (int c = 0; c < NCH; c++) begin
          m_tdr[c] = 0; m_tcr[c] = 0; m_tcnt[c] = 0;
          m_ovf[c] = 1'b0; m_udf[c] = 1'b0;
        end
        m_cyc   = 0;
        m_valid = 1'b1;
      end else begin
        bit wr;
        int ach, aoff;
        wr   = psel && penable && pwrite;
        ach  = int'(paddr) / 4;
        aoff = int'(paddr) % 4;
        for (int c = 0; c < NCH; c++) begin
          int  div, nv;
          bit  tick, so, su, ld, hit;
          div  = 2 << (m_tcr[c] & 3);
          tick = (m_cyc % div) == (div - 1);
          hit  = wr && (ach == c);
          ld   = hit && (aoff == 1) && pwdata[7];
          nv   = m_tcnt[c];
          so   = 1'b0;
          su   = 1'b0;
          if (ld) begin
            nv = m_tdr[c];
          end else if (((m_tcr[c] >> 4) & 1) == 1 && tick) begin
            if (((m_tcr[c] >> 5) & 1) == 0) begin
              nv = m_tcnt[c] + 1;
              if (nv > MAXV) begin
                nv = (((m_tcr[c] >> 6) & 1) == 1) ? m_tdr[c] : 0;
                so = 1'b1;
              end
            end else begin
              nv = m_tcnt[c] - 1;
              if (nv < 0) begin
                nv = (((m_tcr[c] >> 6) & 1) == 1) ? m_tdr[c] : MAXV;
                su = 1'b1;
              end
            end
          end
          m_ovf[c] = so || (m_ovf[c] && !(hit && aoff == 2 && pwdata[0]));
          m_udf[c] = su || (m_udf[c] && !(hit && aoff == 2 && pwdata[1]));
          if (hit && aoff == 0) m_tdr[c] = int'(pwdata);
          if (hit && aoff == 1) m_tcr[c] = int'(pwdata) & 8'h7F;
          m_tcnt[c] = nv;
        end
        m_cyc++;
      end
    end
  end

  function automatic int exp_prdata();
    int ach, aoff;
    ach  = int'(paddr) / 4;
    aoff = int'(paddr) % 4;
    if (!(psel && !pwrite) || ach >= NCH) return 0;
    case (aoff)
      0:       return m_tdr[ach];
      1:       return m_tcr[ach];
      2:       return (m_udf[ach] ? 2 : 0) + (m_ovf[ach] ? 1 : 0);
      default: return m_tcnt[ach];
    endcase
  endfunction

  function automatic bit exp_irq();
    bit r = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (m_ovf[c] && ((m_tcr[c] >> 3) & 1) == 1) r = 1'b1;
      if (m_udf[c] && ((m_tcr[c] >> 2) & 1) == 1) r = 1'b1;
    end
    return r;
  endfunction

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge pclk);
      if (m_valid) begin
        bit e_err;
        e_err = psel && penable &&
                ((int'(paddr) / 4 >= NCH) || (pwrite && int'(paddr) % 4 == 3));
        chk("cyc_prdata",  32'(prdata),  32'(exp_prdata()));
        chk("cyc_pready",  32'(pready),  32'(psel && penable));
        chk("cyc_pslverr", 32'(pslverr), 32'(e_err));
        chk("cyc_tmr_ovf", 32'(tmr_ovf), 32'({m_ovf[1], m_ovf[0]}));
        chk("cyc_tmr_udf", 32'(tmr_udf), 32'({m_udf[1], m_udf[0]}));
        chk("cyc_irq",     32'(irq),     32'(exp_irq()));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // APB driver tasks
  // ---------------------------------------------------------------------------
  task automatic apb_write_now(input int a, input int d, input bit exp_err);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0;
    paddr = 5'(a); pwdata = 8'(d);
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    chk($sformatf("wr_pready_a%0d", a), 32'(pready), 32'(1));
    chk($sformatf("wr_pslverr_a%0d", a), 32'(pslverr), 32'(exp_err));
    $display("apb write addr=%0d data=0x%02h pslverr=%0b", a, d, pslverr);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_write(input int a, input int d, input bit exp_err);
    @(posedge pclk); #1;
    apb_write_now(a, d, exp_err);
  endtask

  task automatic apb_read(input int a, input int exp_d, input bit exp_err);
    @(posedge pclk); #1;
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = 5'(a);
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    chk($sformatf("rd_data_a%0d", a), 32'(prdata), 32'(exp_d));
    chk($sformatf("rd_pready_a%0d", a), 32'(pready), 32'(1));
    chk($sformatf("rd_pslverr_a%0d", a), 32'(pslverr), 32'(exp_err));
    $display("apb read  addr=%0d data=0x%02h pslverr=%0b", a, prdata, pslverr);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // Hold a read of one register and record its value changes.
  int         seq_exp [4];
  int         seq_n;
  logic [1:0] snap_ovf [4];
  logic [1:0] snap_udf [4];
  logic       snap_irq [4];

  task automatic watch(input int a, input int max_cyc, input int gap, input string name);
    int got_v [4];
    int got_c [4];
    int cnt;
    int prev;
    cnt = 0;
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = 5'(a);
    @(negedge pclk);
    prev = int'(prdata);
    for (int k = 1; k <= max_cyc && cnt < seq_n; k++) begin
      @(negedge pclk);
      if (int'(prdata) != prev) begin
        got_v[cnt]    = int'(prdata);
        got_c[cnt]    = k;
        snap_ovf[cnt] = tmr_ovf;
        snap_udf[cnt] = tmr_udf;
        snap_irq[cnt] = irq;
        $display("%s step %0d: count=0x%02h at cycle %0d", name, cnt, prdata, k);
        prev = int'(prdata);
        cnt++;
      end
    end
    @(posedge pclk); #1;
    psel = 1'b0;
    chk({name, "_steps"}, 32'(cnt), 32'(seq_n));
    for (int i = 0; i < cnt; i++) begin
      chk($sformatf("%s_val%0d", name, i), 32'(got_v[i]), 32'(seq_exp[i]));
      if (i > 0) chk($sformatf("%s_gap%0d", name, i), 32'(got_c[i] - got_c[i-1]), 32'(gap));
    end
  endtask

  task automatic idle_read(input int a, input int cycles);
    @(posedge pclk); #1;
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = 5'(a);
    repeat (cycles) @(posedge pclk);
    #1;
    psel = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int  tcnt_before;
    bit  found;

    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;

    // Reset held for two edges; outputs checked while in reset.
    @(posedge pclk);
    @(negedge pclk);
    chk("rst_prdata",  32'(prdata),  32'(0));
    chk("rst_pready",  32'(pready),  32'(0));
    chk("rst_pslverr", 32'(pslverr), 32'(0));
    chk("rst_ovf",     32'(tmr_ovf), 32'(0));
    chk("rst_udf",     32'(tmr_udf), 32'(0));
    chk("rst_irq",     32'(irq),     32'(0));
    @(posedge pclk); #1;
    preset = 1'b0;
    for (int a = 0; a < 4 * NCH; a++) apb_read(a, 0, 1'b0);

    // Channel 0 counts up with auto-reload at cks=0.
    apb_write(0, 8'hFC, 1'b0);
    apb_write(1, 8'h80, 1'b0);
    apb_read(3, 8'hFC, 1'b0);
    apb_read(1, 8'h00, 1'b0);
    apb_write(1, 8'h50, 1'b0);
    seq_n = 4;
    seq_exp = '{8'hFD, 8'hFE, 8'hFF, 8'hFC};
    watch(3, 30, 2, "ch0_up");
    chk("ch0_ovf_before_wrap", 32'(snap_ovf[2]), 32'(2'b00));
    chk("ch0_ovf_at_wrap",     32'(snap_ovf[3]), 32'(2'b01));
    chk("ch0_irq_at_wrap",     32'(snap_irq[3]), 32'(0));
    apb_read(2, 8'h01, 1'b0);
    apb_read(1, 8'h50, 1'b0);
    apb_write(1, 8'h00, 1'b0);
    apb_write(2, 8'h01, 1'b0);
    @(negedge pclk);
    chk("ch0_ovf_cleared", 32'(tmr_ovf), 32'(2'b00));

    // Channel 1 counts down without reload at cks=3.
    apb_write(4, 8'h02, 1'b0);
    apb_write(5, 8'h80, 1'b0);
    apb_write(5, 8'h3B, 1'b0);
    seq_n = 3;
    seq_exp = '{8'h01, 8'h00, 8'hFF, 8'h00};
    watch(7, 80, 16, "ch1_down");
    chk("ch1_udf_before_wrap", 32'(snap_udf[1]), 32'(2'b00));
    chk("ch1_udf_at_wrap",     32'(snap_udf[2]), 32'(2'b10));
    chk("ch1_no_cross_ovf",    32'(snap_ovf[2]), 32'(2'b00));
    chk("ch1_irq_masked",      32'(snap_irq[2]), 32'(0));
    apb_write(5, 8'h3F, 1'b0);
    @(negedge pclk);
    chk("ch1_irq_enabled", 32'(irq), 32'(1));
    apb_write(5, 8'h00, 1'b0);
    apb_write(6, 8'h03, 1'b0);
    @(negedge pclk);
    chk("ch1_udf_cleared", 32'(tmr_udf), 32'(2'b00));
    chk("ch1_irq_cleared", 32'(irq), 32'(0));

    // Same-edge overflow and write-1-to-clear: the flag must survive.
    apb_write(0, 8'hFD, 1'b0);
    apb_write(1, 8'h80, 1'b0);
    apb_write(1, 8'h58, 1'b0);
    @(posedge pclk); #1;
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = 5'd3;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge pclk);
      if (prdata == 8'hFF) found = 1'b1;
    end
    chk("race_sync", 32'(found), 32'(1));
    // FF just arrived on a tick edge; the wrap edge is two edges later,
    // which is exactly where this write commits.
    #1;
    apb_write_now(2, 8'h01, 1'b0);
    @(negedge pclk);
    chk("race_ovf_kept", 32'(tmr_ovf), 32'(2'b01));
    chk("race_irq",      32'(irq),     32'(1));
    apb_write(1, 8'h08, 1'b0);
    @(negedge pclk);
    chk("race_irq_held", 32'(irq), 32'(1));
    apb_write(2, 8'h01, 1'b0);
    @(negedge pclk);
    chk("race_ovf_clear", 32'(tmr_ovf), 32'(2'b00));
    chk("race_irq_fall",  32'(irq),     32'(0));

    // Error responses.
    apb_read(4 * NCH, 0, 1'b1);
    apb_read(4 * NCH + 1, 0, 1'b1);
    apb_write(4 * NCH, 8'h12, 1'b1);
    tcnt_before = m_tcnt[0];
    apb_write(3, 8'h55, 1'b1);
    apb_read(3, tcnt_before, 1'b0);

    // Both channels concurrently: ch0 up cks=0, ch1 down cks=2, both reload.
    apb_write(0, 8'hF8, 1'b0);
    apb_write(1, 8'h80, 1'b0);
    apb_write(4, 8'h03, 1'b0);
    apb_write(5, 8'h80, 1'b0);
    apb_write(1, 8'h50, 1'b0);
    apb_write(5, 8'h72, 1'b0);
    idle_read(3, 40);
    idle_read(7, 40);
    @(negedge pclk);
    chk("indep_ovf", 32'(tmr_ovf), 32'(2'b01));
    chk("indep_udf", 32'(tmr_udf), 32'(2'b10));

    // Reset while counting clears everything.
    @(posedge pclk); #1;
    preset = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b0;
    @(negedge pclk);
    chk("rst2_ovf", 32'(tmr_ovf), 32'(0));
    chk("rst2_udf", 32'(tmr_udf), 32'(0));
    chk("rst2_irq", 32'(irq),     32'(0));
    apb_read(3, 0, 1'b0);
    apb_read(7, 0, 1'b0);
    apb_read(1, 0, 1'b0);
    apb_read(4, 0, 1'b0);

    repeat (2) @(posedge pclk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
